// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with a 2-entry skid buffer on the output side.
// Format comes from opcode auto-decode or an explicit mode; illegal opcodes are counted.
module imm_gen_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned AUTO_DECODE = 0,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [2:0]       mode,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FmtZero  = 3'd0;
  localparam logic [2:0] FmtI     = 3'd1;
  localparam logic [2:0] FmtShamt = 3'd2;
  localparam logic [2:0] FmtU     = 3'd3;
  localparam logic [2:0] FmtJ     = 3'd4;
  localparam logic [2:0] FmtB     = 3'd5;
  localparam logic [2:0] FmtS     = 3'd6;
  localparam logic [2:0] FmtZimm  = 3'd7;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic [2:0]       fmt;
  logic             ill_c;
  logic [XLEN-1:0]  imm_c;
  logic [2:0]       funct3;
  logic             accept, pop, load_out, load_skid, skid_to_out;
  logic [XLEN-1:0]  out_imm_q, skid_imm_q;
  logic [TAG_W-1:0] out_tag_q, skid_tag_q;
  logic             out_ill_q, skid_ill_q;
  logic [CNT_W-1:0] cnt_q;

  assign funct3 = inst[14:12];

  always_comb begin
    fmt   = FmtZero;
    ill_c = 1'b0;
    if (AUTO_DECODE != 0) begin
      case (inst[6:0])
        7'b0010011: fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FmtShamt : FmtI;
        7'b0000011, 7'b1100111: fmt = FmtI;
        7'b0100011: fmt = FmtS;
        7'b1100011: fmt = FmtB;
        7'b0110111, 7'b0010111: fmt = FmtU;
        7'b1101111: fmt = FmtJ;
        7'b1110011: fmt = funct3[2] ? FmtZimm : FmtZero;
        7'b0110011: fmt = FmtZero;
        default: begin
          fmt   = FmtZero;
          ill_c = 1'b1;
        end
      endcase
    end else begin
      fmt = mode;
    end
  end

  always_comb begin
    imm_c = '0;
    case (fmt)
      FmtI:     imm_c = XLEN'($signed(inst[31:20]));
      FmtShamt: imm_c = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
      FmtU:     imm_c = XLEN'($signed({inst[31:12], 12'b0}));
      FmtJ:     imm_c = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      FmtB:     imm_c = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      FmtS:     imm_c = XLEN'($signed({inst[31:25], inst[11:7]}));
      FmtZimm:  imm_c = XLEN'(inst[19:15]);
      default:  imm_c = '0;
    endcase
  end

  // Buffer occupancy FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StEmpty;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (accept) state_d = StOne;
      StOne: begin
        if (accept && !pop)      state_d = StFull;
        else if (!accept && pop) state_d = StEmpty;
      end
      StFull:  if (pop) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    out_valid   = (state_q != StEmpty);
    in_ready    = (state_q != StFull);
    accept      = in_valid && in_ready;
    pop         = out_valid && out_ready;
    load_out    = accept && ((state_q == StEmpty) || (state_q == StOne && pop));
    load_skid   = accept && (state_q == StOne) && !pop;
    skid_to_out = pop && (state_q == StFull);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_imm_q  <= '0;
      out_tag_q  <= '0;
      out_ill_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      if (load_out) begin
        out_imm_q <= imm_c;
        out_tag_q <= tag;
        out_ill_q <= ill_c;
      end else if (skid_to_out) begin
        out_imm_q <= skid_imm_q;
        out_tag_q <= skid_tag_q;
        out_ill_q <= skid_ill_q;
      end
      if (load_skid) begin
        skid_imm_q <= imm_c;
        skid_tag_q <= tag;
        skid_ill_q <= ill_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                 cnt_q <= '0;
    else if (accept && ill_c && cnt_q != '1)   cnt_q <= cnt_q + CNT_W'(1);
  end

  assign imm         = out_imm_q;
  assign out_tag     = out_tag_q;
  assign illegal     = out_ill_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: four instances (auto 32/64-bit, 2-bit counter, explicit
// mode) share one stimulus stream; each task checks the instance relevant to its feature.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] inst = '0;
  logic [2:0]  mode = '0;
  logic [4:0]  tag = '0;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_imm;
  logic [4:0]  a_out_tag;
  logic [15:0] a_cnt;
  logic        w_in_ready, w_out_valid, w_illegal;
  logic [63:0] w_imm;
  logic [4:0]  w_out_tag;
  logic [15:0] w_cnt;
  logic        s_in_ready, s_out_valid, s_illegal;
  logic [31:0] s_imm;
  logic [4:0]  s_out_tag;
  logic [1:0]  s_cnt;
  logic        m_in_ready, m_out_valid, m_illegal;
  logic [31:0] m_imm;
  logic [4:0]  m_out_tag;
  logic [15:0] m_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1), .TAG_W(5), .CNT_W(16)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(a_in_ready), .inst(inst),
    .mode(mode), .tag(tag), .out_valid(a_out_valid), .out_ready(out_ready), .imm(a_imm),
    .out_tag(a_out_tag), .illegal(a_illegal), .illegal_cnt(a_cnt));

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .TAG_W(5), .CNT_W(16)) u_dut64 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(w_in_ready), .inst(inst),
    .mode(mode), .tag(tag), .out_valid(w_out_valid), .out_ready(out_ready), .imm(w_imm),
    .out_tag(w_out_tag), .illegal(w_illegal), .illegal_cnt(w_cnt));

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1), .TAG_W(5), .CNT_W(2)) u_sat (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(s_in_ready), .inst(inst),
    .mode(mode), .tag(tag), .out_valid(s_out_valid), .out_ready(out_ready), .imm(s_imm),
    .out_tag(s_out_tag), .illegal(s_illegal), .illegal_cnt(s_cnt));

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .TAG_W(5), .CNT_W(16)) u_man (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(m_in_ready), .inst(inst),
    .mode(mode), .tag(tag), .out_valid(m_out_valid), .out_ready(out_ready), .imm(m_imm),
    .out_tag(m_out_tag), .illegal(m_illegal), .illegal_cnt(m_cnt));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #2;
    checks++;
    if (a_out_valid !== 1'b0 || a_imm !== 32'h0 || a_out_tag !== 5'h0 || a_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b imm=%h tag=%h ill=%b want 0/0/0/0",
               a_out_valid, a_imm, a_out_tag, a_illegal);
    end
    checks++;
    if (a_cnt !== 16'h0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cnt_ready: got cnt=%h rdy=%b want 0/1", a_cnt, a_in_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    step();
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b v=%b want 1/0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] vin [4];
    logic [31:0] vexp [4];
    vin  = '{32'hFFF00093, 32'hFE000EE3, 32'h123452B7, 32'h3002D073};
    vexp = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h00000005};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst = vin[i];
      tag = 5'(i + 1);
      in_valid = 1'b1;
      step();
      checks++;
      if (a_out_valid !== 1'b1 || a_imm !== vexp[i] || a_out_tag !== 5'(i + 1)
          || a_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b imm=%h tag=%0d rdy=%b want 1/%h/%0d/1", i,
                 a_out_valid, a_imm, a_out_tag, a_in_ready, vexp[i], i + 1);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: got v=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_shamt();
    inst = 32'h03F09093;
    tag = 5'd4;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (w_imm !== 64'd63 || w_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL shamt_xlen64: got imm=%0d v=%b want 63/1", w_imm, w_out_valid);
    end
    checks++;
    if (a_imm !== 32'd31) begin
      errors++;
      $display("FAIL shamt_xlen32: got imm=%0d want 31", a_imm);
    end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tag = 5'(t);
      inst = {12'(t), 20'h00013};
      step();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_tag !== 5'd1 || a_imm !== 32'd1
          || a_in_ready !== (t == 1)) begin
        errors++;
        $display("FAIL bp_stall_%0d: got v=%b tag=%0d imm=%0d rdy=%b want 1/1/1/%0d", t,
                 a_out_valid, a_out_tag, a_imm, a_in_ready, t == 1);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (a_out_valid !== 1'b1 || a_out_tag !== 5'd2 || a_imm !== 32'd2 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_pop2: got v=%b tag=%0d imm=%0d rdy=%b want 1/2/2/1",
               a_out_valid, a_out_tag, a_imm, a_in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_tag !== 5'd3 || a_imm !== 32'd3) begin
      errors++;
      $display("FAIL bp_pop3: got v=%b tag=%0d imm=%0d want 1/3/3",
               a_out_valid, a_out_tag, a_imm);
    end
    step();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: got v=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    out_ready = 1'b1;
    inst = 32'h0000007F;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tag = 5'(10 + i);
      step();
      checks++;
      if (a_illegal !== 1'b1 || a_imm !== 32'h0 || a_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL illegal_%0d: got ill=%b imm=%h v=%b want 1/0/1", i,
                 a_illegal, a_imm, a_out_valid);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (a_cnt !== 16'd2) begin
      errors++;
      $display("FAIL illegal_cnt: got %0d want 2", a_cnt);
    end
    checks++;
    if (m_illegal !== 1'b0 || m_cnt !== 16'd0) begin
      errors++;
      $display("FAIL illegal_manual: got ill=%b cnt=%0d want 0/0", m_illegal, m_cnt);
    end
    step();
  endtask

  task automatic test_saturate();
    apply_reset();
    out_ready = 1'b1;
    inst = 32'h0000007F;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) step();
    in_valid = 1'b0;
    checks++;
    if (s_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat_cnt: got %0d want 3", s_cnt);
    end
    checks++;
    if (a_cnt !== 16'd6) begin
      errors++;
      $display("FAIL wide_cnt: got %0d want 6", a_cnt);
    end
    step();
  endtask

  task automatic test_manual();
    logic [2:0]  mv [3];
    logic [31:0] me [3];
    mv = '{3'd6, 3'd7, 3'd0};
    me = '{32'hFFFFFFE1, 32'h00000000, 32'h00000000};
    out_ready = 1'b1;
    inst = 32'hFFF00093;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mode = mv[i];
      tag = 5'(20 + i);
      step();
      checks++;
      if (m_imm !== me[i] || m_illegal !== 1'b0 || m_out_tag !== 5'(20 + i)) begin
        errors++;
        $display("FAIL manual_mode%0d: got imm=%h ill=%b tag=%0d want %h/0/%0d", mv[i],
                 m_imm, m_illegal, m_out_tag, me[i], 20 + i);
      end
    end
    in_valid = 1'b0;
    mode = 3'd0;
    step();
  endtask

  task automatic test_reset_midop();
    apply_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    tag = 5'd7;
    inst = {12'd7, 20'h00013};
    step();
    tag = 5'd8;
    inst = {12'd8, 20'h00013};
    step();
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_full: got rdy=%b want 0", a_in_ready);
    end
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_imm !== 32'h0 || a_out_tag !== 5'h0) begin
      errors++;
      $display("FAIL midop_async: got v=%b rdy=%b imm=%h tag=%0d want 0/1/0/0",
               a_out_valid, a_in_ready, a_imm, a_out_tag);
    end
    in_valid = 1'b0;
    #2;
    rstn = 1'b1;
    step();
    out_ready = 1'b1;
    in_valid = 1'b1;
    tag = 5'd9;
    inst = {12'd9, 20'h00013};
    step();
    in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_tag !== 5'd9 || a_imm !== 32'd9) begin
      errors++;
      $display("FAIL midop_first: got v=%b tag=%0d imm=%0d want 1/9/9",
               a_out_valid, a_out_tag, a_imm);
    end
    step();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop_alone: got v=%b want 0", a_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_shamt();
    test_back_to_back();
    test_illegal();
    test_saturate();
    test_manual();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the CPU decode stage. It extracts and extends the immediate of every RV32I/RV64I format, including CSR zimm and RV64 6-bit shamt, to `XLEN` bits. The format comes either from an explicit `mode` or from opcode/funct3 auto-decode. Results cross a valid/ready interface through a 2-entry skid buffer, so decode can stall without dropping instructions. The block also counts illegal (unrecognised) opcodes.

## Interface
- `XLEN`, 32, result width; legal values are 32 and 64.
- `AUTO_DECODE`, 0, 1 = derive the format from `inst`; 0 = use `mode`.
- `TAG_W`, 5, width of the sideband tag carried alongside `inst`.
- `CNT_W`, 16, width of the illegal-instruction counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `inst`, `mode` and `tag` are valid.
- `in_ready`  out  1  the block can accept this cycle.
- `inst`  in  32  instruction word.
- `mode`  in  3  format select; ignored when `AUTO_DECODE`=1.
- `tag`  in  `TAG_W`  passthrough, e.g. rd or ROB id.
- `out_valid`  out  1  `imm`, `out_tag` and `illegal` are valid.
- `out_ready`  in  1  the consumer accepts this cycle.
- `imm`  out  `XLEN`  extended immediate.
- `out_tag`  out  `TAG_W`  tag of this result.
- `illegal`  out  1  the opcode is unrecognised (auto mode only).
- `illegal_cnt`  out  `CNT_W`  saturating count of accepted illegal instructions.

## Operation
- `sext(x)` sign-extends `x` to `XLEN`; `zext(x)` zero-extends it.
- Format encodings:
  - 0: zero.
  - 1: I, `sext(inst[31:20])`.
  - 2: shamt, `zext(inst[24:20])` when `XLEN`=32 and `zext(inst[25:20])` when `XLEN`=64.
  - 3: U, `sext({inst[31:12],12'b0})`.
  - 4: J, `sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})`.
  - 5: B, `sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})`.
  - 6: S, `sext({inst[31:25],inst[11:7]})`.
  - 7: zimm, `zext(inst[19:15])`.
- Auto decode maps `inst[6:0]` as follows:
  - 0010011 → shamt if `funct3` is 001 or 101, else I.
  - 0000011 and 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111 and 0010111 → U.
  - 1101111 → J.
  - 1110011 → zimm if `funct3[2]`=1, else zero.
  - 0110011 → zero.
  - Any other opcode → zero with `illegal`=1.
- `illegal` is always 0 when `AUTO_DECODE`=0.
- Immediate computation is combinational on the input. The result is captured at acceptance, i.e. when `in_valid` and `in_ready` are both high.
- Buffer: an output register (OUT) plus a skid register (SKID). `in_ready` = !`skid_valid` and is a registered value.
- Buffer states are EMPTY, ONE (OUT valid) and FULL (OUT and SKID valid):
  - Accept with no pop: EMPTY→ONE, or ONE→FULL when the entry is written to SKID.
  - Pop with no accept: FULL→ONE (SKID moves to OUT), or ONE→EMPTY.
  - Accept and pop in ONE: stay in ONE; the new entry is written to OUT.
  - Accept is impossible in FULL because `in_ready`=0.
- Order is strictly FIFO and no result is ever dropped or duplicated.
- `illegal_cnt` increments on every accepted illegal instruction and saturates at all-ones. It does not wrap.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears with `out_valid`=1 after edge N.
- Throughput is 1 per cycle while `out_ready`=1.
- `in_ready` drops the cycle after the buffer becomes FULL. It rises the cycle after the pop that empties SKID.
- `out_valid`, `imm`, `out_tag` and `illegal` hold stable while `out_valid`=1 and `out_ready`=0.
- When `out_valid`=0 the output data is don't-care but holds its last value.
- Reset, asynchronous on `rstn` low, applies immediately regardless of the clock:
  - `out_valid`=0, `imm`=0, `out_tag`=0, `illegal`=0, `illegal_cnt`=0.
  - `skid_valid`=0, so `in_ready`=1.
  - Any entries in flight are discarded.
- `in_ready` is 1 from the first cycle after `rstn` deasserts.

## Test plan
- `AUTO_DECODE`=1, `XLEN`=32, `out_ready`=1, stream one per cycle:
  - 0xFFF00093 (addi -1) → `imm` 0xFFFFFFFF.
  - 0xFE000EE3 (beq -4) → `imm` 0xFFFFFFFC.
  - 0x123452B7 (lui) → `imm` 0x12345000.
  - 0x3002D073 (csrrwi zimm 5) → `imm` 0x00000005.
  - Each result arrives 1 cycle after acceptance, with tags in order.
- Shamt width, `inst`=0x03F09093 (slli 63): `XLEN`=64 → `imm` 63; `XLEN`=32 → `imm` 31.
- Backpressure: hold `out_ready`=0 and drive 3 back-to-back instructions with tags 1, 2, 3:
  - Tags 1 and 2 are accepted and `in_ready` falls; tag 3 waits.
  - Release `out_ready` → outputs 1, 2, 3 in order, with no loss and no duplicates.
- Illegal opcode: `inst`=0x0000007F, accepted twice → `illegal`=1, `imm`=0 and `illegal_cnt`=2.
  - With `CNT_W`=2, six illegal instructions leave `illegal_cnt`=3 (saturated).
- Explicit mode, `AUTO_DECODE`=0, `inst`=0xFFF00093:
  - `mode`=6 → `imm` 0xFFFFFFE1.
  - `mode`=7 → `imm` 0x00000000.
  - `mode`=0 → `imm` 0.
  - `illegal` stays 0.
- Reset mid-operation: drop `rstn` while FULL and between clock edges → `out_valid`=0 and `in_ready`=1 immediately.
  - After release, the first accepted instruction emerges alone with correct data.
